keypad_scanner: RTL

Matrix-keypad front end that produces the `newkey`/`keycode` stream consumed by the calculator's keypad interpreter. It drives the keypad columns one at a time and samples the row lines through a synchronizer. Each accepted press yields one single-cycle `newkey` pulse with a stable 5-bit `keycode`, after debounce, single-key validation and release detection. It sits between the board-level keypad pins and `keypad_interpreter`.

---
 rtl/keypad_pkg.sv | 48 ++++
 rtl/keypad_keymap.sv | 59 +++++
 rtl/keypad_scanner.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the matrix-keypad front end and its consumer
// (keypad_interpreter). Holds the 5-bit key codes, the per-frame scan
// result encoding, the scanner FSM state encoding and a helper that
// builds hex-digit codes.
//
// Key code format: bit 4 set marks a hex digit whose value is in bits [3:0];
// with bit 4 clear the code names a function key.

package keypad_pkg;

  // Function-key codes
  localparam logic [4:0] ADDKEY    = 5'b01010;
  localparam logic [4:0] SUBKEY    = 5'b00011;
  localparam logic [4:0] MULTKEY   = 5'b00010;
  localparam logic [4:0] EQUALSKEY = 5'b00100;
  localparam logic [4:0] BACKKEY   = 5'b00001;
  localparam logic [4:0] CAKEY     = 5'b01001;
  localparam logic [4:0] CEKEY     = 5'b01100;

  // Flag bit marking a hex-digit code
  localparam logic [4:0] HEXFLAG   = 5'b10000;

  // Number of keypad rows / columns
  localparam int unsigned NUM_ROWS = 5;
  localparam int unsigned NUM_COLS = 5;

  // Result of one full scan frame (all five columns)
  typedef enum logic [1:0] {
    FRAME_NONE   = 2'd0,
    FRAME_SINGLE = 2'd1,
    FRAME_MULTI  = 2'd2
  } frame_res_e;

  // Press/release debounce FSM
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } scan_state_e;

  // Build the code of a hex digit key
  function automatic logic [4:0] hex_code(input logic [3:0] value);
    return HEXFLAG | {1'b0, value};
  endfunction

endpackage

// File: rtl/keypad_keymap.sv
// keypad_keymap
// Combinational key map: translates a matrix position (row, column) into
// a key code plus a valid flag. Positions that carry no key (row 4,
// columns 3..4, and any out-of-range index) report valid_o = 0 so that a
// press there is ignored by the scanner.
//
// Ports:
//   row_i   [2:0]  matrix row index (0..4)
//   col_i   [2:0]  matrix column index (0..4)
//   valid_o        position carries a mapped key
//   code_o  [4:0]  key code (zero when not valid)

module keypad_keymap
  import keypad_pkg::*;
(
  input  logic [2:0] row_i,
  input  logic [2:0] col_i,
  output logic       valid_o,
  output logic [4:0] code_o
);

  always_comb begin
    valid_o = 1'b0;
    code_o  = '0;
    if (row_i < 3'd4 && col_i < 3'd4) begin
      // 4x4 hex block: value = row*4 + col
      valid_o = 1'b1;
      code_o  = hex_code({row_i[1:0], col_i[1:0]});
    end else if (row_i < 3'd4 && col_i == 3'd4) begin
      valid_o = 1'b1;
      case (row_i[1:0])
        2'd0:    code_o = ADDKEY;
        2'd1:    code_o = SUBKEY;
        2'd2:    code_o = MULTKEY;
        default: code_o = EQUALSKEY;
      endcase
    end else if (row_i == 3'd4) begin
      case (col_i)
        3'd0: begin
          valid_o = 1'b1;
          code_o  = BACKKEY;
        end
        3'd1: begin
          valid_o = 1'b1;
          code_o  = CAKEY;
        end
        3'd2: begin
          valid_o = 1'b1;
          code_o  = CEKEY;
        end
        default: begin
          valid_o = 1'b0;
          code_o  = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Matrix-keypad front end. Drives the five columns low one at a time,
// samples the synchronized rows at the end of each column dwell, folds
// the five samples of a frame into NONE / SINGLE(code) / MULTI, and runs
// a press/release debounce FSM that emits one newkey pulse per accepted
// press.
//
// Parameters:
//   SCAN_DIV  clock cycles each column is driven (>= 4)
//   DEBOUNCE  identical frames needed to accept a press or a release (>= 1)
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   row_n    [4:0] keypad rows, active-low, asynchronous to clk
//   col_n    [4:0] column drive, active-low, exactly one low
//   newkey         one-cycle pulse per accepted press
//   keycode  [4:0] code of the last accepted key
//   key_held       high from accept until the release is debounced

module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] row_n,
  output logic [4:0] col_n,
  output logic       newkey,
  output logic [4:0] keycode,
  output logic       key_held
);

  localparam int unsigned DWW = $clog2(SCAN_DIV);
  localparam int unsigned DBW = $clog2(DEBOUNCE + 1);

  localparam logic [DWW-1:0] DWELL_LAST = DWW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DB_TARGET  = DBW'(DEBOUNCE);
  localparam logic [DBW-1:0] DB_ONE     = DBW'(1);
  localparam logic [2:0]     COL_LAST   = 3'd4;

  // ---------------------------------------------------------------------
  // Row synchronizer (idle-high rows, so reset to all ones)
  // ---------------------------------------------------------------------
  logic [4:0] row_meta_q;
  logic [4:0] row_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= row_n;
      row_sync_q <= row_meta_q;
    end
  end

  // ---------------------------------------------------------------------
  // Column scan: dwell counter and column index
  // ---------------------------------------------------------------------
  logic [DWW-1:0] dwell_q;
  logic [2:0]     col_idx_q;
  logic [2:0]     col_idx_d;
  logic [4:0]     col_n_q;
  logic [4:0]     col_n_d;
  logic           dwell_last;
  logic           frame_end;

  assign dwell_last = (dwell_q == DWELL_LAST);
  assign frame_end  = dwell_last && (col_idx_q == COL_LAST);

  always_comb begin
    col_idx_d = (col_idx_q == COL_LAST) ? 3'd0 : col_idx_q + 3'd1;
    col_n_d   = '1;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      col_n_d[c] = (col_idx_d != 3'(c));
    end
  end

  // col_n is registered alongside the index so the pins only ever
  // change on a dwell boundary and never glitch through decode logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q   <= '0;
      col_idx_q <= '0;
      col_n_q   <= 5'b11110;
    end else if (dwell_last) begin
      dwell_q   <= '0;
      col_idx_q <= col_idx_d;
      col_n_q   <= col_n_d;
    end else begin
      dwell_q   <= dwell_q + DWW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Per-column key decode: one keymap per row for the active column
  // ---------------------------------------------------------------------
  logic [4:0] map_valid;
  logic [4:0] map_code [NUM_ROWS];

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_map
    keypad_keymap u_keymap (
      .row_i   (3'(r)),
      .col_i   (col_idx_q),
      .valid_o (map_valid[r]),
      .code_o  (map_code[r])
    );
  end

  logic [2:0] col_hits;
  logic [4:0] col_code;

  always_comb begin
    col_hits = '0;
    col_code = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (!row_sync_q[r] && map_valid[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = map_code[r];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Frame accumulator: saturating hit count (0, 1, 2+) and first code
  // ---------------------------------------------------------------------
  logic [1:0]  acc_cnt_q;
  logic [4:0]  acc_code_q;
  logic [3:0]  hit_total;
  logic [1:0]  acc_cnt_sat;
  logic [4:0]  frame_code;
  frame_res_e  frame_res;

  // The frame result combines the stored columns with the column being
  // sampled this cycle, so it is valid on the frame-end cycle itself.
  always_comb begin
    hit_total   = {2'b00, acc_cnt_q} + {1'b0, col_hits};
    acc_cnt_sat = (hit_total >= 4'd2) ? 2'd2 : hit_total[1:0];
    frame_code  = (acc_cnt_q != 2'd0) ? acc_code_q : col_code;
    if (hit_total == 4'd0) begin
      frame_res = FRAME_NONE;
    end else if (hit_total == 4'd1) begin
      frame_res = FRAME_SINGLE;
    end else begin
      frame_res = FRAME_MULTI;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
    end else if (dwell_last) begin
      if (col_idx_q == COL_LAST) begin
        acc_cnt_q  <= '0;
        acc_code_q <= '0;
      end else begin
        acc_cnt_q  <= acc_cnt_sat;
        acc_code_q <= frame_code;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Debounce FSM (evaluated on frame-end cycles only)
  // ---------------------------------------------------------------------
  scan_state_e    state_q;
  scan_state_e    state_d;
  logic [4:0]     cand_q;
  logic [4:0]     cand_d;
  logic [DBW-1:0] cnt_q;
  logic [DBW-1:0] cnt_d;
  logic           newkey_q;
  logic           newkey_d;
  logic [4:0]     keycode_q;
  logic [4:0]     keycode_d;
  logic           held_q;
  logic           held_d;
  logic           accept;
  logic [4:0]     accept_code;

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    newkey_d    = 1'b0;
    keycode_d   = keycode_q;
    held_d      = held_q;
    accept      = 1'b0;
    accept_code = cand_q;

    if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_res == FRAME_SINGLE) begin
            cand_d = frame_code;
            cnt_d  = DB_ONE;
            if (DEBOUNCE == 1) begin
              accept      = 1'b1;
              accept_code = frame_code;
            end else begin
              state_d = ST_PRESS_DB;
            end
          end
        end

        ST_PRESS_DB: begin
          if (frame_res == FRAME_SINGLE && frame_code == cand_q) begin
            if (cnt_q + DB_ONE == DB_TARGET) begin
              accept      = 1'b1;
              accept_code = cand_q;
            end else begin
              cnt_d = cnt_q + DB_ONE;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end

        ST_HELD: begin
          if (frame_res == FRAME_NONE) begin
            if (DEBOUNCE == 1) begin
              held_d  = 1'b0;
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d   = DB_ONE;
              state_d = ST_RELEASE_DB;
            end
          end
        end

        ST_RELEASE_DB: begin
          if (frame_res == FRAME_NONE) begin
            if (cnt_q + DB_ONE == DB_TARGET) begin
              held_d  = 1'b0;
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + DB_ONE;
            end
          end else begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase

      if (accept) begin
        newkey_d  = 1'b1;
        keycode_d = accept_code;
        held_d    = 1'b1;
        state_d   = ST_HELD;
        cnt_d     = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      newkey_q  <= 1'b0;
      keycode_q <= '0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      newkey_q  <= newkey_d;
      keycode_q <= keycode_d;
      held_q    <= held_d;
    end
  end

  assign col_n    = col_n_q;
  assign newkey   = newkey_q;
  assign keycode  = keycode_q;
  assign key_held = held_q;

endmodule
